// File: rtl/regfile_write_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_sequencer
// Purpose  : Arbitrates the register-file write port between pipeline
//            writeback (A) and a FIFO-buffered multi-cycle unit (B). After
//            reset it clears every register before accepting writes.
// Revision : 1.0
// ============================================================================
module regfile_write_sequencer #(
    parameter int WORD_LEN      = 32,
    parameter int ADDR_LEN      = 4,
    parameter int REG_FILE_SIZE = 16,
    parameter int FIFO_DEPTH    = 4,
    parameter int ZERO_REG_EN   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                a_we,
    input  logic [ADDR_LEN-1:0] a_addr,
    input  logic [WORD_LEN-1:0] a_data,
    input  logic                b_valid,
    output logic                b_ready,
    input  logic [ADDR_LEN-1:0] b_addr,
    input  logic [WORD_LEN-1:0] b_data,
    input  logic [ADDR_LEN-1:0] q_addr,
    output logic                q_pending,
    output logic                busy,
    output logic                rf_we,
    output logic [ADDR_LEN-1:0] rf_addr,
    output logic [WORD_LEN-1:0] rf_data
);

    localparam int c_ptr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [ADDR_LEN-1:0] c_clr_last = ADDR_LEN'(REG_FILE_SIZE - 1);
    localparam logic [c_cnt_w-1:0]  c_full_cnt = c_cnt_w'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t                 state_q;
    logic [ADDR_LEN-1:0]    clr_cnt_q;
    logic                   busy_q;
    logic                   rf_we_q;
    logic [ADDR_LEN-1:0]    rf_addr_q;
    logic [WORD_LEN-1:0]    rf_data_q;

    logic [ADDR_LEN-1:0]    fifo_addr_q [FIFO_DEPTH];
    logic [WORD_LEN-1:0]    fifo_data_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]  valid_q;
    logic [FIFO_DEPTH-1:0]  stale_q;
    logic [c_ptr_w-1:0]     wr_ptr_q;
    logic [c_ptr_w-1:0]     rd_ptr_q;
    logic [c_cnt_w-1:0]     count_q;
    logic [c_cnt_w-1:0]     count_d;

    logic w_run;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_a_zero;
    logic w_head_zero;

    assign w_run       = (state_q == ST_RUN);
    assign w_empty     = (count_q == '0);
    assign b_ready     = w_run && (count_q != c_full_cnt);
    assign w_push      = b_valid && b_ready;
    // Port A always wins; the FIFO only drains on cycles A leaves free.
    assign w_pop       = w_run && !a_we && !w_empty;
    assign w_a_zero    = (ZERO_REG_EN != 0) && (a_addr == '0);
    assign w_head_zero = (ZERO_REG_EN != 0) && (fifo_addr_q[rd_ptr_q] == '0);
    assign count_d     = count_q + c_cnt_w'(w_push) - c_cnt_w'(w_pop);

    assign busy    = busy_q;
    assign rf_we   = rf_we_q;
    assign rf_addr = rf_addr_q;
    assign rf_data = rf_data_q;

    always_comb begin
        q_pending = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (valid_q[i] && !stale_q[i] && (fifo_addr_q[i] == q_addr)) begin
                q_pending = 1'b1;
            end
        end
        if ((ZERO_REG_EN != 0) && (q_addr == '0)) begin
            q_pending = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            busy_q    <= 1'b1;
            rf_we_q   <= 1'b0;
            rf_addr_q <= '0;
            rf_data_q <= '0;
            valid_q   <= '0;
            stale_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            // busy falls one cycle after the last clear write is presented
            busy_q <= (state_q == ST_CLEAR);
            case (state_q)
                ST_CLEAR: begin
                    rf_we_q   <= 1'b1;
                    rf_addr_q <= clr_cnt_q;
                    rf_data_q <= '0;
                    clr_cnt_q <= clr_cnt_q + ADDR_LEN'(1);
                    if (clr_cnt_q == c_clr_last) begin
                        state_q <= ST_RUN;
                    end
                end
                default: begin
                    if (a_we) begin
                        rf_we_q   <= !w_a_zero;
                        rf_addr_q <= a_addr;
                        rf_data_q <= a_data;
                        // A is younger than everything queued: older B writes to the same register are dead
                        if (!w_a_zero) begin
                            for (int i = 0; i < FIFO_DEPTH; i++) begin
                                if (valid_q[i] && (fifo_addr_q[i] == a_addr)) begin
                                    stale_q[i] <= 1'b1;
                                end
                            end
                        end
                    end else if (!w_empty) begin
                        rf_we_q   <= !stale_q[rd_ptr_q] && !w_head_zero;
                        rf_addr_q <= fifo_addr_q[rd_ptr_q];
                        rf_data_q <= fifo_data_q[rd_ptr_q];
                        valid_q[rd_ptr_q] <= 1'b0;
                        stale_q[rd_ptr_q] <= 1'b0;
                        rd_ptr_q  <= rd_ptr_q + c_ptr_w'(1);
                    end else begin
                        rf_we_q <= 1'b0;
                    end
                    if (w_push) begin
                        fifo_addr_q[wr_ptr_q] <= b_addr;
                        fifo_data_q[wr_ptr_q] <= b_data;
                        valid_q[wr_ptr_q]     <= 1'b1;
                        stale_q[wr_ptr_q]     <= 1'b0;
                        wr_ptr_q              <= wr_ptr_q + c_ptr_w'(1);
                    end
                    count_q <= count_d;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_write_sequencer
// Purpose  : Directed and randomized stimulus against a queue-based model.
// Revision : 1.0
// ============================================================================
module tb_regfile_write_sequencer;

    localparam int WL  = 32;
    localparam int AL  = 4;
    localparam int RFS = 16;
    localparam int FD  = 4;
    localparam int Z   = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_we;
    logic [AL-1:0] a_addr;
    logic [WL-1:0] a_data;
    logic          b_valid;
    logic          b_ready;
    logic [AL-1:0] b_addr;
    logic [WL-1:0] b_data;
    logic [AL-1:0] q_addr;
    logic          q_pending;
    logic          busy;
    logic          rf_we;
    logic [AL-1:0] rf_addr;
    logic [WL-1:0] rf_data;

    regfile_write_sequencer #(
        .WORD_LEN(WL), .ADDR_LEN(AL), .REG_FILE_SIZE(RFS),
        .FIFO_DEPTH(FD), .ZERO_REG_EN(Z)
    ) dut (
        .clk(clk), .rst(rst),
        .a_we(a_we), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .q_addr(q_addr), .q_pending(q_pending), .busy(busy),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AL-1:0] addr;
        logic [WL-1:0] data;
        bit            stale;
    } ent_t;

    ent_t          mq[$];
    int            clr_m;
    bit            inited;
    bit            e_we;
    logic [AL-1:0] e_addr;
    logic [WL-1:0] e_data;
    bit            e_busy;
    int            n_checks;
    int            n_fail;

    task automatic check(input string tag, input logic [WL-1:0] obs, input logic [WL-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit m_ready();
        return (clr_m == RFS) && (mq.size() < FD);
    endfunction

    function automatic bit m_pend(input logic [AL-1:0] a);
        if (Z != 0 && a == '0) return 1'b0;
        foreach (mq[i]) if (!mq[i].stale && mq[i].addr == a) return 1'b1;
        return 1'b0;
    endfunction

    // Called just after a negedge with inputs already driven.
    task automatic tick();
        bit   rdy;
        ent_t e;
        #1;
        if (inited) begin
            check("b_ready", {31'd0, b_ready}, {31'd0, m_ready()});
            check("q_pending", {31'd0, q_pending}, {31'd0, m_pend(q_addr)});
        end
        rdy = m_ready();
        @(posedge clk);
        if (rst) begin
            mq.delete();
            clr_m  = 0;
            e_we   = 1'b0;
            e_addr = '0;
            e_data = '0;
            e_busy = 1'b1;
            inited = 1'b1;
        end else if (inited) begin
            e_busy = (clr_m < RFS);
            if (clr_m < RFS) begin
                e_we   = 1'b1;
                e_addr = AL'(clr_m);
                e_data = '0;
                clr_m++;
            end else begin
                if (a_we) begin
                    e_we   = !(Z != 0 && a_addr == '0);
                    e_addr = a_addr;
                    e_data = a_data;
                    if (e_we) foreach (mq[i]) if (mq[i].addr == a_addr) mq[i].stale = 1'b1;
                end else if (mq.size() > 0) begin
                    e      = mq.pop_front();
                    e_we   = !e.stale && !(Z != 0 && e.addr == '0);
                    e_addr = e.addr;
                    e_data = e.data;
                end else begin
                    e_we = 1'b0;
                end
                if (b_valid && rdy) mq.push_back('{addr: b_addr, data: b_data, stale: 1'b0});
            end
        end
        #1;
        if (inited) begin
            check("rf_we", {31'd0, rf_we}, {31'd0, e_we});
            if (e_we) begin
                check("rf_addr", {28'd0, rf_addr}, {28'd0, e_addr});
                check("rf_data", rf_data, e_data);
            end
            check("busy", {31'd0, busy}, {31'd0, e_busy});
        end
        @(negedge clk);
    endtask

    task automatic idle();
        a_we = 1'b0; b_valid = 1'b0;
    endtask

    task automatic drive_a(input logic [AL-1:0] ad, input logic [WL-1:0] d);
        a_we = 1'b1; a_addr = ad; a_data = d;
    endtask

    task automatic drive_b(input logic [AL-1:0] ad, input logic [WL-1:0] d);
        b_valid = 1'b1; b_addr = ad; b_data = d;
    endtask

    task automatic do_reset();
        rst = 1'b1; tick(); rst = 1'b0;
    endtask

    initial begin
        n_checks = 0; n_fail = 0; inited = 1'b0; clr_m = 0;
        rst = 1'b1; a_addr = '0; a_data = '0; b_addr = '0; b_data = '0; q_addr = '0;
        idle();
        do_reset();
        repeat (RFS + 2) tick();

        // Priority: A for three cycles while B waits behind it
        q_addr = 4'd5;
        drive_a(4'd1, 32'h101); drive_b(4'd5, 32'hAA); tick();
        b_valid = 1'b0;
        drive_a(4'd2, 32'h102); tick();
        drive_a(4'd3, 32'h103); tick();
        idle(); repeat (3) tick();

        // Backpressure with continuous A, then drain with wrap-around
        for (int i = 0; i < 7; i++) begin
            drive_a(4'd8, 32'h800 + i);
            drive_b(AL'(10 + (i % 5)), 32'hB00 + i);
            q_addr = AL'(10 + (i % 5));
            tick();
        end
        idle();
        repeat (6) tick();

        // Stale kill
        q_addr = 4'd7;
        drive_b(4'd7, 32'h11); tick();
        b_valid = 1'b0;
        drive_a(4'd7, 32'h22); tick();
        idle(); repeat (3) tick();

        // Same-cycle same-address
        q_addr = 4'd9;
        drive_a(4'd9, 32'h1); drive_b(4'd9, 32'h2); tick();
        idle(); repeat (3) tick();

        // Zero register suppression
        q_addr = 4'd0;
        drive_a(4'd0, 32'h55); drive_b(4'd0, 32'h66); tick();
        idle(); repeat (3) tick();

        // Reset mid-clear with a queued entry present beforehand
        drive_b(4'd3, 32'h33); tick(); idle();
        do_reset();
        while (clr_m < 7) tick();
        q_addr = 4'd3;
        do_reset();
        repeat (RFS + 2) tick();

        // Randomized traffic with address collisions and occasional reset
        for (int n = 0; n < 3000; n++) begin
            a_we    = ($urandom % 3) == 0;
            a_addr  = AL'($urandom % 6);
            a_data  = $urandom;
            b_valid = ($urandom % 2) == 0;
            b_addr  = AL'($urandom % 6);
            b_data  = $urandom;
            q_addr  = AL'($urandom % 6);
            rst     = ($urandom % 600) == 0;
            tick();
            rst = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_write_sequencer.md
Name: regfile_write_sequencer

Overview:
- Owns the single write port of the register file and shares it between two writers.
  - Port A: pipeline writeback. Highest priority, no backpressure.
  - Port B: multi-cycle unit (load/mul). Valid/ready handshake, buffered in a small FIFO.
- After reset, sequences a clear of every register, one address per cycle.
- Provides a combinational pending-write query so the hazard unit can stall readers of registers with queued B writes.

Parameters:
- WORD_LEN, 32, data width.
- ADDR_LEN, 4, register address width.
- REG_FILE_SIZE, 16, number of registers cleared after reset (≤ 2^ADDR_LEN).
- FIFO_DEPTH, 4, Port B buffer entries (power of 2, ≥2).
- ZERO_REG_EN, 1, when 1 all writes to address 0 are suppressed (except clear).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- a_we  in  1  Port A write request; always accepted unless clearing.
- a_addr  in  ADDR_LEN  Port A destination.
- a_data  in  WORD_LEN  Port A value.
- b_valid  in  1  Port B request valid.
- b_ready  out  1  Port B can accept (combinational).
- b_addr  in  ADDR_LEN  Port B destination.
- b_data  in  WORD_LEN  Port B value.
- q_addr  in  ADDR_LEN  pending-write query address.
- q_pending  out  1  a live FIFO entry targets q_addr (combinational).
- busy  out  1  clear sequence in progress.
- rf_we  out  1  register file write enable (registered).
- rf_addr  out  ADDR_LEN  register file write address (registered).
- rf_data  out  WORD_LEN  register file write data (registered).

Behaviour:
- Reset (rst high at posedge):
  - state←CLEAR, clear counter←0, FIFO emptied, all valid/stale bits cleared.
  - rf_we/rf_addr/rf_data←0, busy←1.
- CLEAR:
  - Each cycle: rf_we←1, rf_addr←counter, rf_data←0, counter++.
  - After issuing address REG_FILE_SIZE-1: state←RUN, busy←0 the next cycle. Clear takes exactly REG_FILE_SIZE cycles of rf_we.
  - b_ready=0; a_we ignored (dropped).
  - rst asserted mid-clear restarts from address 0.
- RUN, output selection each posedge (priority order):
  1. a_we=1: rf_we←1, rf_addr/rf_data←a_addr/a_data.
  2. else FIFO head live: output head, pop.
  3. else FIFO head stale: pop with rf_we←0.
  4. else rf_we←0.
- Suppression: with ZERO_REG_EN=1, any a/b write to addr 0 drives rf_we←0.
  - The B entry is still consumed.
  - A write to addr 0 neither kills nor is blocked.
- Latency: A request at posedge N appears on rf_* after posedge N (one cycle). B write appears ≥2 cycles after acceptance.
- Handshake: b_ready = (state==RUN) && FIFO not full. Transfer when b_valid && b_ready; enqueue at that posedge.
- Full/empty:
  - Full ⇒ b_ready=0. Push and pop in the same cycle while full is not allowed, because b_ready is already low.
  - Push into empty FIFO: entry not eligible for output until next cycle.
  - Simultaneous push+pop when neither full nor empty keeps occupancy.
  - Pointers wrap modulo FIFO_DEPTH.
- Ordering rule: an accepted A write is younger than every entry already in the FIFO.
  - On an A write to X (X≠0 or ZERO_REG_EN=0), every existing entry with addr X is marked stale.
  - A B entry pushed in the same cycle as A to the same X is NOT killed; it is younger and is written later.
- q_pending=1 iff any valid, non-stale FIFO entry has addr==q_addr. The same-cycle incoming b request is not counted. Forced 0 for q_addr=0 when ZERO_REG_EN=1.
- Data width: pass-through only, no arithmetic beyond pointer/counter increments.

Test Plan:
- Reset clear: rst 1 cycle, REG_FILE_SIZE=16 → rf_we=1 for 16 consecutive cycles with rf_addr 0..15, rf_data=0, busy=1 throughout. Next cycle busy=0, b_ready=1.
- Priority: a_we every cycle for 3 cycles (addr 1..3) while B pushes addr 5 data 0xAA → rf_* shows 1, 2, 3, then 5/0xAA. q_pending(5)=1 until 0xAA is written.
- Backpressure: hold b_valid with a_we high continuously, FIFO_DEPTH=4 → exactly 4 transfers, then b_ready=0. Drop a_we → entries drain in FIFO order with wrap-around; b_ready returns 1 after the first pop.
- Stale kill: B enqueues addr 7 = 0x11, then A writes addr 7 = 0x22 → rf shows 0x22 only. Next slot has rf_we=0, the stale pop. q_pending(7) drops after the A accept.
- Same-cycle same-address: A addr 9 = 0x1 and B addr 9 = 0x2 at one posedge → rf writes 0x1, then 0x2.
- Zero register and reset mid-op: A and B to addr 0 → rf_we never 1 for them. Assert rst at clear address 6 → clear restarts at 0, FIFO empty, q_pending=0.
